// File: rtl/ram_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_rr_arbiter_if
// Bundles the requester-side handshake and the shared RAM port of the
// four-way round-robin RAM arbiter.
//
// Signals (widths follow RAM_WIDTH / ADDR_WIDTH):
//   req_valid[3:0], req_we[3:0]     per-requester request valid / write
//   req_addr[4*ADDR_WIDTH-1:0]      requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_din [4*RAM_WIDTH-1:0]       requester i at [i*RAM_WIDTH  +: RAM_WIDTH]
//   req_ready[3:0]                  one-hot grant
//   rsp_valid[3:0], rsp_data        read-data strobe per requester / shared data
//   ram_en, ram_we, ram_regce       RAM port controls
//   ram_addr, ram_din, ram_dout     RAM data path
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters plus RAM)
// ----------------------------------------------------------------------------
interface ram_rr_arbiter_if #(
    parameter int RAM_WIDTH  = 18,
    parameter int ADDR_WIDTH = 10
);
    logic [3:0]              req_valid;
    logic [3:0]              req_we;
    logic [4*ADDR_WIDTH-1:0] req_addr;
    logic [4*RAM_WIDTH-1:0]  req_din;
    logic [3:0]              req_ready;
    logic [3:0]              rsp_valid;
    logic [RAM_WIDTH-1:0]    rsp_data;
    logic                    ram_en;
    logic                    ram_we;
    logic                    ram_regce;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [RAM_WIDTH-1:0]    ram_din;
    logic [RAM_WIDTH-1:0]    ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_din, ram_dout,
        output req_ready, rsp_valid, rsp_data,
        output ram_en, ram_we, ram_regce, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_din, ram_dout,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_en, ram_we, ram_regce, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ram_rr_arbiter
// Four-way round-robin arbiter in front of a single RAM port. One request is
// granted per cycle; the grant drives the RAM combinationally. Reads carry a
// {valid, id} tag down a RD_LATENCY-deep pipeline so the read data coming out
// of the RAM is strobed back to the right requester on rsp_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        ram_rr_arbiter_if.slave (requester handshake + RAM port)
//   stats_clr  (RAM_ARB_STATS_EN only) clear all grant counters
//   grant_cnt  (RAM_ARB_STATS_EN only) 4 x 16-bit saturating grant counters
//
// Parameters:
//   RAM_WIDTH, ADDR_WIDTH  RAM data / address widths
//   RD_LATENCY             RAM read latency, 1 or 2 cycles
//
// Optional feature macro: RAM_ARB_STATS_EN (per-requester grant counters).
// ----------------------------------------------------------------------------
module ram_rr_arbiter #(
    parameter int RAM_WIDTH  = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_rr_arbiter_if.slave       bus
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [63:0]           grant_cnt
`endif
);

    // ------------------------------------------------------------------
    // Per-requester slices
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_arr [4];
    logic [RAM_WIDTH-1:0]  din_arr  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign din_arr[gi]  = bus.req_din[gi*RAM_WIDTH +: RAM_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [1:0] last_grant_q;
    logic [1:0] cand;
    logic       found;
    logic [1:0] grant_id;
    logic [3:0] grant_oh;
    logic       grant_we;

    // Search starts one past the last winner and wraps naturally in 2 bits.
    always_comb begin
        found    = 1'b0;
        grant_id = 2'd0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && bus.req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        // Nothing is granted while reset is held.
        if (rst) begin
            found    = 1'b0;
            grant_id = 2'd0;
        end
    end

    assign grant_oh = found ? (4'b0001 << grant_id) : 4'b0000;
    assign grant_we = found & bus.req_we[grant_id];

    // Pointer moves only on a grant; idle cycles keep the priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 2'd3;
        end else if (found) begin
            last_grant_q <= grant_id;
        end
    end

    // ------------------------------------------------------------------
    // RAM port, driven straight from the winner
    // ------------------------------------------------------------------
    assign bus.req_ready = grant_oh;
    assign bus.ram_en    = found;
    assign bus.ram_we    = grant_we;
    assign bus.ram_regce = 1'b1;
    assign bus.ram_addr  = found ? addr_arr[grant_id] : '0;
    assign bus.ram_din   = found ? din_arr[grant_id]  : '0;

    // ------------------------------------------------------------------
    // Read tag pipeline: stage s holds reads granted s+1 cycles ago, so the
    // last stage lines up with ram_dout for the configured latency. It
    // shifts every cycle regardless of new grants, so a read can be issued
    // in the same cycle another response returns.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] tag_v_q;
    logic [1:0]            tag_id_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_id_q[s] <= 2'd0;
            end
        end else begin
            tag_v_q[0]  <= found & ~grant_we;
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    logic [3:0] rsp_oh;

    // Gated by rst so a tag still in the last stage when reset rises
    // cannot escape as a pulse.
    always_comb begin
        rsp_oh = 4'b0000;
        if (tag_v_q[RD_LATENCY-1] && !rst) begin
            rsp_oh[tag_id_q[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign bus.rsp_valid = rsp_oh;
    // No data register here: read data is whatever the RAM presents.
    assign bus.rsp_data  = bus.ram_dout;

`ifdef RAM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-requester grant counters; clear wins over increment.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [15:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst || stats_clr) begin
                    cnt_q <= 16'd0;
                end else if (grant_oh[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_rr_arbiter
// Directed bench for ram_rr_arbiter. Two instances share the same requester
// stimulus: dut2 with RD_LATENCY=2 and dut1 with RD_LATENCY=1, each behind its
// own no-change RAM model. Inputs change and outputs are sampled just after
// the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_rr_arbiter;
    localparam int RW = 18;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_we;
    logic [4*AW-1:0]   req_addr;
    logic [4*RW-1:0]   req_din;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ram_rr_arbiter_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) if1 ();
    ram_rr_arbiter_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) if2 ();

    assign if1.req_valid = req_valid;
    assign if1.req_we    = req_we;
    assign if1.req_addr  = req_addr;
    assign if1.req_din   = req_din;
    assign if2.req_valid = req_valid;
    assign if2.req_we    = req_we;
    assign if2.req_addr  = req_addr;
    assign if2.req_din   = req_din;

    // RAM models: write does not touch the read register (no-change mode).
    logic [RW-1:0] mem1 [1024];
    logic [RW-1:0] mem2 [1024];
    logic [RW-1:0] m1_r1;
    logic [RW-1:0] m2_r1;
    logic [RW-1:0] m2_r2;

    always @(posedge clk) begin
        if (if1.ram_en) begin
            if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_din;
            else            m1_r1 <= mem1[if1.ram_addr];
        end
        if (if2.ram_en) begin
            if (if2.ram_we) mem2[if2.ram_addr] <= if2.ram_din;
            else            m2_r1 <= mem2[if2.ram_addr];
        end
        if (if2.ram_regce) m2_r2 <= m2_r1;
    end
    assign if1.ram_dout = m1_r1;
    assign if2.ram_dout = m2_r2;

`ifdef RAM_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] gc1;
    logic [63:0] gc2;
`endif

    ram_rr_arbiter #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if1)
`ifdef RAM_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (gc1)
`endif
    );

    ram_rr_arbiter #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if2)
`ifdef RAM_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (gc2)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        req_valid = 4'b0000;
        tick();
        rst       = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        tick();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_we    = 4'hF;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", if2.req_ready); else pass_cnt++;
        chk_cnt++; if (if2.ram_en !== 1'b0) $display("FAIL rst_ram_en: got %b want 0", if2.ram_en); else pass_cnt++;
        chk_cnt++; if (if2.ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", if2.ram_we); else pass_cnt++;
        chk_cnt++; if (if2.rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid: got %b want 0000", if2.rsp_valid); else pass_cnt++;
        chk_cnt++; if (if2.ram_regce !== 1'b1) $display("FAIL ram_regce: got %b want 1", if2.ram_regce); else pass_cnt++;
        chk_cnt++; if (if1.req_ready !== 4'b0000) $display("FAIL rst_ready_l1: got %b want 0000", if1.req_ready); else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0001) $display("FAIL rst_first_grant: got %b want 0001", if2.req_ready); else pass_cnt++;
        $display("reset: first grant %b", if2.req_ready);
        tick();
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        do_reset();
        tick();
        req_valid = 4'b0100;
        req_we    = 4'b0100;
        req_addr  = '0;
        req_din   = '0;
        req_addr[2*AW +: AW] = 10'd7;
        req_din[2*RW +: RW]  = 18'h155;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0100) $display("FAIL wr_ready: got %b want 0100", if2.req_ready); else pass_cnt++;
        chk_cnt++; if (if2.ram_en !== 1'b1 || if2.ram_we !== 1'b1) $display("FAIL wr_en_we: got %b%b want 11", if2.ram_en, if2.ram_we); else pass_cnt++;
        chk_cnt++; if (if2.ram_addr !== 10'd7) $display("FAIL wr_addr: got %h want 007", if2.ram_addr); else pass_cnt++;
        chk_cnt++; if (if2.ram_din !== 18'h155) $display("FAIL wr_din: got %h want 155", if2.ram_din); else pass_cnt++;
        $display("write: req2 addr=%h data=%h", if2.ram_addr, if2.ram_din);
        tick();
        req_we = 4'b0000;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0100 || if2.ram_we !== 1'b0) $display("FAIL rd_grant: got %b/%b want 0100/0", if2.req_ready, if2.ram_we); else pass_cnt++;
        chk_cnt++; if (if1.rsp_valid !== 4'b0000) $display("FAIL wr_no_rsp_l1: got %b want 0000", if1.rsp_valid); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (if1.rsp_valid !== 4'b0100 || if1.rsp_data !== 18'h155) $display("FAIL rd_rsp_l1: got %b/%h want 0100/155", if1.rsp_valid, if1.rsp_data); else pass_cnt++;
        chk_cnt++; if (if2.rsp_valid !== 4'b0000) $display("FAIL rd_early_l2: got %b want 0000", if2.rsp_valid); else pass_cnt++;
        tick();
        #1;
        chk_cnt++; if (if2.rsp_valid !== 4'b0100 || if2.rsp_data !== 18'h155) $display("FAIL rd_rsp_l2: got %b/%h want 0100/155", if2.rsp_valid, if2.rsp_data); else pass_cnt++;
        chk_cnt++; if (if1.rsp_valid !== 4'b0000) $display("FAIL rd_once_l1: got %b want 0000", if1.rsp_valid); else pass_cnt++;
        $display("read: req2 rsp data=%h", if2.rsp_data);
        tick();
        #1;
        chk_cnt++; if (if2.rsp_valid !== 4'b0000) $display("FAIL rd_once_l2: got %b want 0000", if2.rsp_valid); else pass_cnt++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention();
        logic [3:0] exp_g;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            req_valid = 4'hF;
            req_we    = 4'hF;
            for (int i = 0; i < 4; i++) begin
                req_addr[i*AW +: AW] = 10'(10'h100 + i);
                req_din[i*RW +: RW]  = 18'(i);
            end
            #1;
            exp_g = 4'b0001 << (k % 4);
            chk_cnt++; if (if2.req_ready !== exp_g) $display("FAIL contention_%0d: got %b want %b", k, if2.req_ready, exp_g); else pass_cnt++;
            chk_cnt++; if (if1.req_ready !== exp_g) $display("FAIL contention_l1_%0d: got %b want %b", k, if1.req_ready, exp_g); else pass_cnt++;
            chk_cnt++; if ((if1.rsp_valid | if2.rsp_valid) !== 4'b0000) $display("FAIL contention_no_rsp_%0d: got %b/%b want 0000", k, if1.rsp_valid, if2.rsp_valid); else pass_cnt++;
            $display("contention: cycle %0d grant %b", k, if2.req_ready);
        end
        tick();
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream();
        int         n1;
        int         n3;
        int         j;
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        logic [RW-1:0] exp_d;
        // Requester 0 fills 0x20..0x23 with 0x10..0x13 and 0x30..0x33 with 0x14..0x17.
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 4'b0001;
            req_we    = 4'b0001;
            req_addr[0 +: AW] = (i < 4) ? 10'(10'h20 + i) : 10'(10'h30 + i - 4);
            req_din[0 +: RW]  = 18'(18'h10 + i);
            #1;
            chk_cnt++; if (if2.req_ready !== 4'b0001) $display("FAIL fill_%0d: got %b want 0001", i, if2.req_ready); else pass_cnt++;
        end
        n1 = 0;
        n3 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            req_we = 4'b0000;
            if (k < 8) begin
                req_valid = {(n3 < 4), 1'b0, (n1 < 4), 1'b0};
                req_addr[1*AW +: AW] = 10'(10'h20 + n1);
                req_addr[3*AW +: AW] = 10'(10'h30 + n3);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (k < 8) begin
                exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
                chk_cnt++; if (if2.req_ready !== exp_g) $display("FAIL stream_grant_%0d: got %b want %b", k, if2.req_ready, exp_g); else pass_cnt++;
            end
            // latency 1 instance
            j = k - 1;
            exp_v = (j >= 0 && j < 8) ? ((j % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            exp_d = (j % 2 == 0) ? 18'(18'h10 + j / 2) : 18'(18'h14 + j / 2);
            chk_cnt++; if (if1.rsp_valid !== exp_v) $display("FAIL stream_l1_valid_%0d: got %b want %b", k, if1.rsp_valid, exp_v); else pass_cnt++;
            if (exp_v != 4'b0000) begin
                chk_cnt++; if (if1.rsp_data !== exp_d) $display("FAIL stream_l1_data_%0d: got %h want %h", k, if1.rsp_data, exp_d); else pass_cnt++;
                $display("stream lat1: rsp %b data %h", if1.rsp_valid, if1.rsp_data);
            end
            // latency 2 instance
            j = k - 2;
            exp_v = (j >= 0 && j < 8) ? ((j % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            exp_d = (j % 2 == 0) ? 18'(18'h10 + j / 2) : 18'(18'h14 + j / 2);
            chk_cnt++; if (if2.rsp_valid !== exp_v) $display("FAIL stream_l2_valid_%0d: got %b want %b", k, if2.rsp_valid, exp_v); else pass_cnt++;
            if (exp_v != 4'b0000) begin
                chk_cnt++; if (if2.rsp_data !== exp_d) $display("FAIL stream_l2_data_%0d: got %h want %h", k, if2.rsp_data, exp_d); else pass_cnt++;
                $display("stream lat2: rsp %b data %h", if2.rsp_valid, if2.rsp_data);
            end
            if (if2.req_ready[1]) n1++;
            if (if2.req_ready[3]) n3++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midflight();
        do_reset();
        tick();
        req_valid = 4'b0010;
        req_we    = 4'b0000;
        req_addr[1*AW +: AW] = 10'h20;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0010) $display("FAIL mid_grant: got %b want 0010", if2.req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        chk_cnt++; if ((if1.rsp_valid | if2.rsp_valid) !== 4'b0000) $display("FAIL mid_rst_cycle: got %b/%b want 0000", if1.rsp_valid, if2.rsp_valid); else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++; if ((if1.rsp_valid | if2.rsp_valid) !== 4'b0000) $display("FAIL mid_after1: got %b/%b want 0000", if1.rsp_valid, if2.rsp_valid); else pass_cnt++;
        tick();
        #1;
        chk_cnt++; if ((if1.rsp_valid | if2.rsp_valid) !== 4'b0000) $display("FAIL mid_after2: got %b/%b want 0000", if1.rsp_valid, if2.rsp_valid); else pass_cnt++;
        tick();
        req_valid = 4'hF;
        req_we    = 4'hF;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", if2.req_ready); else pass_cnt++;
        $display("reset mid-flight: first grant %b", if2.req_ready);
        tick();
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_idle_hold();
        do_reset();
        tick();
        req_valid = 4'b0010;
        req_we    = 4'b0110;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0010) $display("FAIL idle_first: got %b want 0010", if2.req_ready); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            req_valid = 4'b0000;
            #1;
            chk_cnt++; if (if2.req_ready !== 4'b0000 || if2.ram_en !== 1'b0 || if2.ram_we !== 1'b0) $display("FAIL idle_quiet_%0d: got %b/%b/%b want 0000/0/0", k, if2.req_ready, if2.ram_en, if2.ram_we); else pass_cnt++;
        end
        tick();
        req_valid = 4'b0110;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0100) $display("FAIL idle_hold: got %b want 0100", if2.req_ready); else pass_cnt++;
        tick();
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0010) $display("FAIL idle_next: got %b want 0010", if2.req_ready); else pass_cnt++;
        $display("idle hold: grants 2 then 1");
        tick();
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_drop();
        do_reset();
        tick();
        req_valid = 4'b1001;
        req_we    = 4'b1001;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0001) $display("FAIL drop_first: got %b want 0001", if2.req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b0000 || if2.ram_en !== 1'b0) $display("FAIL drop_quiet: got %b/%b want 0000/0", if2.req_ready, if2.ram_en); else pass_cnt++;
        tick();
        req_valid = 4'b1000;
        #1;
        chk_cnt++; if (if2.req_ready !== 4'b1000) $display("FAIL drop_return: got %b want 1000", if2.req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
    endtask

`ifdef RAM_ARB_STATS_EN
    // ------------------------------------------------------------------
    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            req_valid = 4'b0001;
            req_we    = 4'b0001;
        end
        tick();
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (gc2[15:0] !== 16'd5) $display("FAIL cnt_five: got %0d want 5", gc2[15:0]); else pass_cnt++;
        chk_cnt++; if (gc2[63:16] !== 48'd0) $display("FAIL cnt_others: got %h want 0", gc2[63:16]); else pass_cnt++;
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        #1;
        chk_cnt++; if (gc2[15:0] !== 16'd0) $display("FAIL cnt_clr: got %0d want 0", gc2[15:0]); else pass_cnt++;
        tick();
        stats_clr = 1'b1;
        req_valid = 4'b0001;
        tick();
        stats_clr = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (gc2[15:0] !== 16'd0) $display("FAIL cnt_clr_prio: got %0d want 0", gc2[15:0]); else pass_cnt++;
        for (int k = 0; k < 65535; k++) begin
            tick();
            req_valid = 4'b0001;
        end
        tick();
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (gc2[15:0] !== 16'hFFFF) $display("FAIL cnt_full: got %h want ffff", gc2[15:0]); else pass_cnt++;
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        #1;
        chk_cnt++; if (gc2[15:0] !== 16'hFFFF || gc1[15:0] !== 16'hFFFF) $display("FAIL cnt_sat: got %h/%h want ffff", gc2[15:0], gc1[15:0]); else pass_cnt++;
        $display("stats: counter saturated at %h", gc2[15:0]);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_we    = 4'b0000;
        req_addr  = '0;
        req_din   = '0;
`ifdef RAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_contention();
        test_stream();
        test_reset_midflight();
        test_idle_hold();
        test_drop();
`ifdef RAM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 18: data width of the shared RAM port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: RAM address width.
REQ-003 SHALL have parameter RD_LATENCY, default 2: RAM read latency in cycles; legal values are 1 (LOW_LATENCY) and 2 (HIGH_PERFORMANCE).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 4 bits: per-requester request valid.
REQ-007 SHALL have port req_we, input, 4 bits: per-requester write (1) or read (0).
REQ-008 SHALL have port req_addr, input, 4*ADDR_WIDTH bits: requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port req_din, input, 4*RAM_WIDTH bits: write data, sliced per requester in the same way.
REQ-010 SHALL have port req_ready, output, 4 bits: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port rsp_valid, output, 4 bits: one-cycle read-data strobe per requester.
REQ-012 SHALL have port rsp_data, output, RAM_WIDTH bits: read data, shared by all requesters.
REQ-013 SHALL have ports ram_en, ram_we, ram_regce, output, 1 bit each: enable, write enable and output register enable to the RAM port.
REQ-014 SHALL have ports ram_addr (ADDR_WIDTH), ram_din (RAM_WIDTH), output; and ram_dout (RAM_WIDTH), input: the RAM data path.

Function
REQ-015 SHALL grant at most one requester per cycle, using round-robin priority: the search starts at (last_grant+1) mod 4 and takes the first requester with req_valid high.
REQ-016 SHALL drive req_ready combinationally from the current req_valid and the priority pointer; req_ready SHALL be 0 for every requester whose req_valid is low.
REQ-017 SHALL update last_grant only in a cycle where a grant occurs; idle cycles SHALL hold the pointer.
REQ-018 SHALL drive the RAM combinationally from the granted requester:
- ram_en = 1 on any grant;
- ram_we = req_we of the granted requester;
- ram_addr and ram_din = the granted requester's slices;
- when there is no grant, ram_en = 0 and ram_we = 0.
REQ-019 SHALL tie ram_regce to 1.
REQ-020 SHALL carry {valid, id} for each granted read through a tag pipeline RD_LATENCY stages deep.
REQ-021 SHALL assert rsp_valid[id] for exactly one cycle, RD_LATENCY cycles after the read grant, with rsp_data = ram_dout in that cycle.
REQ-022 SHALL NOT produce a rsp_valid pulse for writes.
REQ-023 SHALL accept one read per cycle back-to-back; responses SHALL return in grant order with no stalls and no backpressure on responses.
REQ-024 SHALL keep the tag pipeline independent of grants: a new read in the same cycle as a returning response is legal.
REQ-025 SHALL leave same-address ordering to the RAM's no-change semantics: a write issues no read, and a later read returns the written value.
REQ-026 SHALL rotate fairly when all four requesters hold valid continuously: grants follow 0,1,2,3,0,... and no requester waits more than 3 cycles.
REQ-027 SHALL let a requester that drops valid before being granted lose no state and cause no side effects.

Reset
REQ-028 SHALL, while rst is high: set last_grant = 3, so requester 0 has top priority after reset; clear the tag pipeline; and drive req_ready = 0, rsp_valid = 0, ram_en = 0 and ram_we = 0.
REQ-029 SHALL reset rsp_data only through the RAM; the arbiter holds no data register.
REQ-030 SHALL discard reads in flight when rst is asserted mid-operation; no rsp_valid pulse SHALL appear for them after reset.

Configuration
REQ-031 SHALL, when macro RAM_ARB_STATS_EN is defined, add:
- input stats_clr, 1 bit;
- output grant_cnt, 4*16 bits: one 16-bit grant counter per requester that increments on each grant to that requester, saturates at 0xFFFF, and is cleared by rst or stats_clr (stats_clr takes priority over an increment in the same cycle).
REQ-032 SHALL, when RAM_ARB_STATS_EN is not defined, have no stats_clr or grant_cnt ports and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover single write then read: requester 2 writes 0x155 to addr 7, then reads addr 7 -> rsp_valid = 4'b0100 exactly RD_LATENCY cycles after the read grant, with rsp_data = 0x155.
REQ-034 SHALL cover full contention: all four valid for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; each req_ready is one-hot.
REQ-035 SHALL cover streamed reads: requesters 1 and 3 each read 4 consecutive addresses holding the values 0x10..0x17 -> 8 responses in grant order, with correct id per pulse and no missing pulses, for both RD_LATENCY=1 and RD_LATENCY=2.
REQ-036 SHALL cover reset mid-flight: issue a read, assert rst for 1 cycle in the next cycle -> no rsp_valid pulse, and the first grant after reset goes to requester 0.
REQ-037 SHALL cover idle pointer hold: grant requester 1, idle 3 cycles, then requesters 1 and 2 both valid -> requester 2 is granted first.
REQ-038 SHALL, with RAM_ARB_STATS_EN defined, cover counters: 5 grants to requester 0 -> grant_cnt[15:0] = 5; pulse stats_clr -> 0; preload to 0xFFFF then grant -> stays 0xFFFF.
